adder_bist_checker: RTL
=======================

Name: adder_bist_checker

Overview:
Synthesizable self-checking stimulus/response engine for the combinational adders in the adder library (cla_4 and peers). It drives every {A, B, Cin} vector into a connected adder, samples Sum/Cout after a programmable settle time, and compares them against a golden A+B+Cin. It reports error count, the first failing vector and pass/done. It is the on-chip checking end of the adder interface and can be used in simulation or on FPGA.

Parameters:
WIDTH, 4, operand width of the adder under test (1..8)
SETTLE, 1, cycles the vector is held before sampling (>=1)
ERR_W, 16, width of error counter (saturating)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a sweep when not busy
dut_a  output  WIDTH  operand A to adder, registered
dut_b  output  WIDTH  operand B to adder, registered
dut_cin  output  1  carry-in to adder, registered
dut_sum  input  WIDTH  adder Sum
dut_cout  input  1  adder Cout
busy  output  1  sweep in progress
done  output  1  sweep complete; held until next accepted start or rst
pass  output  1  done && err_count==0
err_count  output  ERR_W  mismatching vectors, saturates at all-ones
vec_count  output  2*WIDTH+2  vectors checked so far
first_fail_valid  output  1  at least one mismatch captured
first_fail_a  output  WIDTH  A of first mismatch
first_fail_b  output  WIDTH  B of first mismatch
first_fail_cin  output  1  Cin of first mismatch

Behaviour:
- Reset: all outputs 0, FSM in IDLE, vector index 0, settle counter 0. rst wins over every other input, including mid-sweep; the sweep is aborted and nothing is retained.
- Vector index idx, 2*WIDTH+1 bits. Decode: A=idx[2W:W+1], B=idx[W:1], Cin=idx[0]. The sweep runs idx 0 to 2^(2W+1)-1 in ascending order.
- Golden is the (WIDTH+1)-bit zero-extended sum A+B+Cin. Mismatch if {dut_cout,dut_sum} != golden.
- FSM states:
  - IDLE: busy=0. On start: clear err_count, vec_count and first_fail_* to 0; clear done and pass; load idx=0 and drive vector 0; go to SETTLE.
  - SETTLE: busy=1. Hold drive registers. After SETTLE cycles in this state, go to CHECK.
  - CHECK: one cycle, busy=1. Sample dut_sum/dut_cout and compare. vec_count+1. On mismatch: err_count+1 (saturating). If first_fail_valid==0, capture A/B/Cin and set first_fail_valid. If idx is the last vector, go to DONE. Otherwise idx+1, load the next vector into the drive registers, and go to SETTLE.
  - DONE: busy=0, done=1, pass per definition. Drive registers hold the last vector. start restarts the sweep exactly as from IDLE.
- Latency: each vector costs SETTLE+1 cycles. For WIDTH=4 and SETTLE=1 that is 512 vectors and 1024 cycles. done rises on the 1024th rising edge after the edge that accepts start.
- start while busy is ignored: no restart and no counter effect.
- Combinational adder assumption: outputs must be stable within SETTLE cycles of the drive-register update.
- err_count saturation: once all-ones it stays there. vec_count does not saturate; it is sized for the full sweep.

Test Plan:
- Correct 4-bit CLA connected, start pulse -> busy for 1024 cycles; then done=1, pass=1, err_count=0, vec_count=512, first_fail_valid=0.
- Fault model: Sum[0] stuck at 0 -> err_count=256, first_fail A=0 B=0 Cin=1, pass=0.
- Fault model: Cout stuck at 0 -> err_count=256, first_fail A=0 B=15 Cin=1.
- rst asserted at cycle 300 of a sweep -> next cycle all outputs 0 and busy=0. A new start then completes a clean sweep of 1024 cycles.
- start pulsed repeatedly while busy -> sweep still ends at cycle 1024 with vec_count=512. start in DONE -> counters cleared and second sweep identical.
- SETTLE=3, with a model adding a 2-cycle output delay -> pass=1 after 2048 cycles. The same model with SETTLE=1 -> pass=0.

Source files
------------

// File: rtl/adder_bist_checker.sv
// adder_bist_checker: sweeps every {A, B, Cin} vector into an external
// combinational adder, waits a programmable settle time, then compares
// {Cout, Sum} with a golden A+B+Cin.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, nothing driven since reset
// S_SETTLE | vector held on dut_a/dut_b/dut_cin, settle timer counting down
// S_CHECK  | one cycle: sample adder outputs, update counters, step vector
// S_DONE   | sweep finished, results held, start begins a new sweep
module adder_bist_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH+1:0] vec_count,
    output logic               first_fail_valid,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b,
    output logic               first_fail_cin
);

    localparam int IW = 2*WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // Timer counts SETTLE-1 down to 0, giving SETTLE cycles in S_SETTLE.
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_nx;
    logic [CW-1:0]   cnt;
    logic [WIDTH:0]  golden;
    logic            mismatch;
    logic            last_vec;
    logic            accept;

    // Golden sum from the drive registers, which always mirror idx.
    always_comb begin
        golden   = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
        mismatch = ({dut_cout, dut_sum} != golden);
        last_vec = &idx;
        idx_nx   = idx + 1'b1;
        accept   = start && ((state == S_IDLE) || (state == S_DONE));
    end

    // pass is derived so it can never disagree with done/err_count.
    assign pass = done && (err_count == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state and busy decode.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (last_vec) state_nx = S_DONE;
                else          state_nx = S_SETTLE;
            end
            S_DONE: begin
                if (start) state_nx = S_SETTLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Settle down-counter: reloaded whenever a new vector is driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept || ((state == S_CHECK) && !last_vec)) begin
            cnt <= CNT_LOAD;
        end else if ((state == S_SETTLE) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Vector index, drive registers and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx              <= '0;
            dut_a            <= '0;
            dut_b            <= '0;
            dut_cin          <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            vec_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_a     <= '0;
            first_fail_b     <= '0;
            first_fail_cin   <= 1'b0;
        end else if (accept) begin
            idx              <= '0;
            dut_a            <= '0;
            dut_b            <= '0;
            dut_cin          <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            vec_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_a     <= '0;
            first_fail_b     <= '0;
            first_fail_cin   <= 1'b0;
        end else if (state == S_CHECK) begin
            vec_count <= vec_count + 1'b1;
            if (mismatch) begin
                if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_a     <= dut_a;
                    first_fail_b     <= dut_b;
                    first_fail_cin   <= dut_cin;
                end
            end
            if (last_vec) begin
                done <= 1'b1;
            end else begin
                idx     <= idx_nx;
                dut_a   <= idx_nx[IW-1:WIDTH+1];
                dut_b   <= idx_nx[WIDTH:1];
                dut_cin <= idx_nx[0];
            end
        end
    end

endmodule
